nibble_pair_rx: RTL



---
 rtl/nibble_pkg.sv | 15 +
 rtl/nibble_timeout_cnt.sv | 29 ++
 rtl/nibble_pair_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types and constants for the A/B nibble pair receiver.
package nibble_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/nibble_timeout_cnt.sv
// Idle-cycle counter for a partial pair; o_expire fires on the increment that would reach TIMEOUT.
module nibble_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  // Counter only ever holds 0..TIMEOUT-1, since it wraps to zero on expiry.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  assign o_expire = i_inc && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/nibble_pair_rx.sv
// Reassembles A/B tagged beats into a parallel pair with valid/ready output and error tracking.
// Optional pair comparator enabled by defining NIBBLE_PAIR_CHECK_EN.
module nibble_pair_rx
  import nibble_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
`ifdef NIBBLE_PAIR_CHECK_EN
  input  logic [2*WIDTH-1:0] expected_code,
  output logic               match,
`endif
  output logic [CNT_W-1:0]   err_cnt
);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_outA;
  logic [WIDTH-1:0] r_outB;
  logic             r_err;
  logic [CNT_W-1:0] r_errCnt;

  logic w_inReady;
  logic w_accept;
  logic w_loadA;
  logic w_loadB;
  logic w_errEvent;
  logic w_toClear;
  logic w_toInc;
  logic w_toExpire;

  assign w_inReady = (r_state != S_FULL);
  assign w_accept  = in_valid && w_inReady;

  // The counter only advances while waiting for B, and any accepted beat restarts the wait.
  assign w_toInc   = (r_state == S_HAVE_A) && !w_accept;
  assign w_toClear = (r_state != S_HAVE_A) || w_accept;

  nibble_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_toClear),
    .i_inc    (w_toInc),
    .o_expire (w_toExpire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_errEvent  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_sel == SLOT_A) begin
            w_loadA     = 1'b1;
            w_nextState = S_HAVE_A;
          end else begin
            w_errEvent = 1'b1;
          end
        end
      end
      S_HAVE_A: begin
        // An accepted B beat takes precedence over a timeout in the same cycle.
        if (w_accept) begin
          if (in_sel == SLOT_B) begin
            w_loadB     = 1'b1;
            w_nextState = S_FULL;
          end else begin
            w_loadA    = 1'b1;
            w_errEvent = 1'b1;
          end
        end else if (w_toExpire) begin
          w_errEvent  = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outA <= '0;
      r_outB <= '0;
    end else begin
      if (w_loadA) begin
        r_outA <= in_data;
      end
      if (w_loadB) begin
        r_outB <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err    <= 1'b0;
      r_errCnt <= '0;
    end else begin
      r_err <= w_errEvent;
      if (w_errEvent && (r_errCnt != {CNT_W{1'b1}})) begin
        r_errCnt <= r_errCnt + CNT_W'(1);
      end
    end
  end

`ifdef NIBBLE_PAIR_CHECK_EN
  logic r_match;

  // Evaluated against the incoming B beat so the result lands together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
    end else if (w_loadB) begin
      r_match <= ({in_data, r_outA} == expected_code);
    end
  end

  assign match = r_match;
`endif

  assign in_ready  = w_inReady;
  assign out_valid = (r_state == S_FULL);
  assign out_a     = r_outA;
  assign out_b     = r_outB;
  assign err       = r_err;
  assign err_cnt   = r_errCnt;

endmodule
